arbitro_memoria_datos: RTL and testbench

Sequences and shares the single-port data memory (CELDAS words, synchronous 1-cycle read, synchronous write) between two requesters: the pipeline MEM stage, which issues loads and stores, and the debug unit, which issues read-only dumps.
- Converts byte addresses to word indices, validates them and drives the memory port.
- Round-robin arbitration between the two requesters.
- Stalls the pipeline until its access completes.
- Sits between the MEM stage/debug unit and the data memory.

---
 rtl/arbitro_pkg.sv | 10 +
 rtl/chequeo_direccion.sv | 13 +
 rtl/arbitro_memoria_datos.sv | 68 ++++++
 tb/tb_arbitro_memoria_datos.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared state encoding and requester IDs for the data-memory arbiter
package arbitro_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RET_P = 2'd1,
    RET_D = 2'd2
  } estado_t;
  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;
endpackage

// File: rtl/chequeo_direccion.sv
// chequeo_direccion: byte address to word index plus alignment/range validity
module chequeo_direccion #(
  parameter int NBITS     = 32,
  parameter int CELDAS    = 10,
  parameter int ADDR_BITS = $clog2(CELDAS)
) (
  input  logic [NBITS-1:0]     addr,
  output logic [ADDR_BITS-1:0] indice,
  output logic                 valido
);
  assign indice = addr[ADDR_BITS+1:2];
  assign valido = addr[1:0] == 2'b00 && 32'(indice) < 32'(CELDAS) && addr[NBITS-1:ADDR_BITS+2] == '0;
endmodule

// File: rtl/arbitro_memoria_datos.sv
// arbitro_memoria_datos: round-robin sharing of the single-port data memory between MEM stage and debug
module arbitro_memoria_datos
  import arbitro_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int CELDAS    = 10,
  parameter int ADDR_BITS = $clog2(CELDAS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_MemRead,
  input  logic                 i_MemWrite,
  input  logic [NBITS-1:0]     i_ALUDireccion,
  input  logic [NBITS-1:0]     i_DatoRegistro,
  output logic [NBITS-1:0]     o_DatoLeido,
  output logic                 o_Stall,
  input  logic                 i_DbgReq,
  input  logic [NBITS-1:0]     i_DbgAddr,
  output logic                 o_DbgAck,
  output logic [NBITS-1:0]     o_DbgDato,
  output logic [ADDR_BITS-1:0] o_MemAddr,
  output logic [NBITS-1:0]     o_MemWData,
  output logic                 o_MemWE,
  output logic                 o_MemRE,
  input  logic [NBITS-1:0]     i_MemRData,
  output logic                 o_Error
);
  estado_t estado;
  logic last_grant, rd_ok, valido, pipe_req, libre, gnt_d, gnt_p, carga;
  logic [NBITS-1:0] dato_q, dbg_q, rdata_m, addr;
  logic [ADDR_BITS-1:0] indice;
  assign pipe_req = i_MemRead | i_MemWrite;
  // grants are combinational, so they are masked while reset is held
  assign libre = i_reset && estado == IDLE;
  assign gnt_d = libre && i_DbgReq && (!pipe_req || last_grant == REQ_PIPE);
  assign gnt_p = libre && pipe_req && !gnt_d;
  assign carga = gnt_p && i_MemRead && !i_MemWrite;
  assign addr  = gnt_d ? i_DbgAddr : i_ALUDireccion;
  chequeo_direccion #(.NBITS(NBITS), .CELDAS(CELDAS), .ADDR_BITS(ADDR_BITS)) u_chequeo (
    .addr  (addr),
    .indice(indice),
    .valido(valido)
  );
  assign rdata_m     = rd_ok ? i_MemRData : '0;
  assign o_MemAddr   = (gnt_p || gnt_d) ? indice : '0;
  assign o_MemWData  = (gnt_p && i_MemWrite) ? i_DatoRegistro : '0;
  assign o_MemWE     = gnt_p && i_MemWrite && valido;
  assign o_MemRE     = valido && (carga || gnt_d);
  assign o_Error     = (gnt_p || gnt_d) && (!valido || (gnt_p && i_MemRead && i_MemWrite));
  assign o_Stall     = i_reset && pipe_req && !(estado == RET_P || (gnt_p && i_MemWrite));
  assign o_DatoLeido = estado == RET_P ? rdata_m : dato_q;
  assign o_DbgAck    = estado == RET_D;
  assign o_DbgDato   = estado == RET_D ? rdata_m : dbg_q;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      estado     <= IDLE;
      last_grant <= REQ_DBG;
      rd_ok      <= 1'b0;
      dato_q     <= '0;
      dbg_q      <= '0;
    end else begin
      estado <= gnt_d ? RET_D : carga ? RET_P : IDLE;
      if (gnt_p || gnt_d) last_grant <= gnt_d ? REQ_DBG : REQ_PIPE;
      rd_ok <= valido;
      if (estado == RET_P) dato_q <= rdata_m;
      if (estado == RET_D) dbg_q <= rdata_m;
    end
endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// tb_arbitro_memoria_datos: directed scenarios then randomized transactions against a memory model
module tb_arbitro_memoria_datos;
  logic        clk = 1'b0, rst_n, fill;
  logic        mr, mw, dreq;
  logic [31:0] alu, wd, daddr, rdata;
  logic [31:0] dato, dbg_dato, mwdata;
  logic        stall, ack, we, re, err;
  logic [3:0]  maddr;
  logic [31:0] mem [0:15];
  logic [31:0] model [0:15];
  int n_pass = 0, n_tot = 0, n_fail = 0;
  int last_srv;

  always #5 clk = ~clk;

  arbitro_memoria_datos dut (
    .i_clk(clk), .i_reset(rst_n), .i_MemRead(mr), .i_MemWrite(mw),
    .i_ALUDireccion(alu), .i_DatoRegistro(wd), .o_DatoLeido(dato), .o_Stall(stall),
    .i_DbgReq(dreq), .i_DbgAddr(daddr), .o_DbgAck(ack), .o_DbgDato(dbg_dato),
    .o_MemAddr(maddr), .o_MemWData(mwdata), .o_MemWE(we), .o_MemRE(re),
    .i_MemRData(rdata), .o_Error(err)
  );

  always @(posedge clk)
    if (fill) begin
      for (int i = 0; i < 16; i++) mem[i[3:0]] <= 32'(i + 1);
    end else begin
      if (we) mem[maddr] <= mwdata;
      if (re) rdata <= mem[maddr];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chb(input string tag, input logic obs, input logic exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit vld(input logic [31:0] a);
    return a % 4 == 0 && a / 4 < 10;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    int r;
    r = $urandom % 8;
    a = 32'($urandom_range(0, 11)) * 4;
    if (r == 0) a = a + 32'($urandom_range(1, 3));
    if (r == 1) a = a | 32'h100;
    return a;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fill = 1'b1;
    mr = 1'b1; mw = 1'b0; dreq = 1'b1; alu = 32'h0; wd = 32'h0; daddr = 32'h0;
    repeat (2) cyc();
    chb("rst_stall", stall, 1'b0);
    chb("rst_re", re, 1'b0);
    chb("rst_ack", ack, 1'b0);
    chb("rst_err", err, 1'b0);
    chk("rst_dato", dato, 32'h0);
    chk("rst_addr", 32'(maddr), 32'h0);
    fill = 1'b0; mr = 1'b0; dreq = 1'b0; rst_n = 1'b1;
    cyc();
    // store then load at 0x8
    mw = 1'b1; alu = 32'h8; wd = 32'hDEADBEEF;
    #1;
    chb("st_we", we, 1'b1);
    chk("st_addr", 32'(maddr), 32'd2);
    chk("st_wdata", mwdata, 32'hDEADBEEF);
    chb("st_stall", stall, 1'b0);
    chb("st_err", err, 1'b0);
    cyc(); mw = 1'b0; mr = 1'b1;
    #1;
    chb("ld_re", re, 1'b1);
    chb("ld_stall1", stall, 1'b1);
    cyc(); #1;
    chb("ld_stall2", stall, 1'b0);
    chk("ld_dato", dato, 32'hDEADBEEF);
    cyc(); mr = 1'b0;
    #1;
    chk("ld_hold", dato, 32'hDEADBEEF);
    chb("ld_idle_stall", stall, 1'b0);
    // debug read of word 9
    cyc(); dreq = 1'b1; daddr = 32'h24;
    #1;
    chb("dbg_re", re, 1'b1);
    chk("dbg_addr", 32'(maddr), 32'd9);
    chb("dbg_ack0", ack, 1'b0);
    cyc(); #1;
    chb("dbg_ack1", ack, 1'b1);
    chk("dbg_dato", dbg_dato, 32'd10);
    cyc(); dreq = 1'b0;
    #1;
    chb("dbg_ack2", ack, 1'b0);
    chk("dbg_hold", dbg_dato, 32'd10);
    // simultaneous requests alternate
    cyc(); mr = 1'b1; alu = 32'h0; dreq = 1'b1; daddr = 32'h4;
    #1;
    chk("tie1_addr", 32'(maddr), 32'd0);
    chb("tie1_stall", stall, 1'b1);
    chb("tie1_ack", ack, 1'b0);
    cyc(); #1;
    chb("tie2_stall", stall, 1'b0);
    chk("tie2_dato", dato, 32'd1);
    cyc(); #1;
    chk("tie3_addr", 32'(maddr), 32'd1);
    chb("tie3_re", re, 1'b1);
    chb("tie3_stall", stall, 1'b1);
    cyc(); #1;
    chb("tie4_ack", ack, 1'b1);
    chk("tie4_dbg", dbg_dato, 32'd2);
    chb("tie4_stall", stall, 1'b1);
    cyc(); #1;
    chk("tie5_addr", 32'(maddr), 32'd0);
    chb("tie5_ack", ack, 1'b0);
    chb("tie5_stall", stall, 1'b1);
    cyc(); #1;
    chb("tie6_stall", stall, 1'b0);
    cyc(); mr = 1'b0; dreq = 1'b0;
    #1;
    chb("tie7_re", re, 1'b0);
    // invalid addresses
    cyc(); mw = 1'b1; alu = 32'h28; wd = 32'h55;
    #1;
    chb("oor_we", we, 1'b0);
    chb("oor_err", err, 1'b1);
    chb("oor_stall", stall, 1'b0);
    cyc(); mw = 1'b0; mr = 1'b1; alu = 32'h6;
    #1;
    chb("mis_re", re, 1'b0);
    chb("mis_err", err, 1'b1);
    chb("mis_stall", stall, 1'b1);
    cyc(); #1;
    chb("mis_stall2", stall, 1'b0);
    chk("mis_dato", dato, 32'h0);
    chb("mis_err2", err, 1'b0);
    // read and write together
    cyc(); mw = 1'b1; alu = 32'h4; wd = 32'hCAFEF00D;
    #1;
    chb("rw_we", we, 1'b1);
    chb("rw_re", re, 1'b0);
    chb("rw_err", err, 1'b1);
    chb("rw_stall", stall, 1'b0);
    chk("rw_addr", 32'(maddr), 32'd1);
    cyc(); mr = 1'b0; mw = 1'b0;
    #1;
    chb("rw_noret", stall, 1'b0);
    chk("rw_hold", dato, 32'h0);
    // reset during RET_D
    cyc(); dreq = 1'b1; daddr = 32'h4;
    #1;
    chb("rd_re", re, 1'b1);
    cyc(); rst_n = 1'b0;
    #1;
    chb("rd_rst_ack", ack, 1'b0);
    chk("rd_rst_dbg", dbg_dato, 32'h0);
    chb("rd_rst_re", re, 1'b0);
    cyc(); rst_n = 1'b1;
    #1;
    chb("rd_re2", re, 1'b1);
    chk("rd_addr2", 32'(maddr), 32'd1);
    chb("rd_ack2", ack, 1'b0);
    cyc(); #1;
    chb("rd_ack3", ack, 1'b1);
    chk("rd_dbg3", dbg_dato, 32'hCAFEF00D);
    cyc(); dreq = 1'b0;
    // randomized transactions
    for (int i = 0; i < 16; i++) model[i[3:0]] = 32'(i + 1);
    model[2] = 32'hDEADBEEF;
    model[1] = 32'hCAFEF00D;
    last_srv = 1;
    for (int t = 0; t < 60; t++) begin
      int k, first, errs, exp_err, exp_first;
      logic [31:0] pa, da, pd;
      bit pv, dv, pdone, ddone, pst;
      k = int'($urandom % 4);
      pa = rnd_addr(); da = rnd_addr(); pd = $urandom;
      pv = vld(pa); dv = vld(da);
      pdone = (k == 2); ddone = (k < 2); pst = (k == 0);
      exp_first = (last_srv == 1) ? 0 : 1;
      exp_err = 0;
      if (!pdone && !pv) exp_err++;
      if (!ddone && !dv) exp_err++;
      mr = (k == 1 || k == 3); mw = (k == 0); alu = pa; wd = pd;
      dreq = (k >= 2); daddr = da;
      first = -1; errs = 0;
      for (int c = 0; c < 10 && !(pdone && ddone); c++) begin
        #1;
        if (err) errs++;
        if (!pdone && !stall) begin
          pdone = 1;
          if (first < 0) first = 0;
          if (pst) begin
            if (pv) model[pa[5:2]] = pd;
          end else chk("rnd_load", dato, pv ? model[pa[5:2]] : 32'h0);
          last_srv = 0;
        end
        if (!ddone && ack) begin
          ddone = 1;
          if (first < 0) first = 1;
          chk("rnd_dbg", dbg_dato, dv ? model[da[5:2]] : 32'h0);
          last_srv = 1;
        end
        cyc();
        if (pdone) begin mr = 1'b0; mw = 1'b0; end
        if (ddone) dreq = 1'b0;
      end
      chb("rnd_done", pdone && ddone, 1'b1);
      chk("rnd_err", 32'(errs), 32'(exp_err));
      if (k == 3) chk("rnd_tie_order", 32'(first), 32'(exp_first));
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
